// File: rtl/aether_stfq_ranker_pkg.sv
// Shared types and helpers for the Aether STFQ ranker and its PIFO push path.
// Widths, the push word layout and the rank arithmetic helpers live here.
// Optional feature macro used by the ranker files: STFQ_WEIGHT_EN.
package aether_pifo_pkg;

  localparam int PTW       = 16;  // rank width, matches PIFO priority field
  localparam int MTW       = 32;  // metadata width, passed through untouched
  localparam int FLOW_ID_W = 4;   // flow index width
  localparam int LEN_W     = 11;  // packet length width in bytes
  localparam int SHIFT_W   = 4;   // per-flow weight shift width

  localparam int NUM_FLOWS = 1 << FLOW_ID_W;

  typedef logic [PTW-1:0]       rank_t;
  typedef logic [FLOW_ID_W-1:0] flow_t;
  typedef logic [LEN_W-1:0]     len_t;
  typedef logic [MTW-1:0]       meta_t;
  typedef logic [SHIFT_W-1:0]   shift_t;

  localparam rank_t RANK_MAX = '1;

  // Push word seen by the PIFO: rank sits in the low PTW bits.
  typedef struct packed {
    meta_t meta;
    rank_t rank;
  } push_word_t;

  // Rank addition that clamps at the top of the rank space instead of wrapping.
  function automatic rank_t sat_add(input rank_t a, input rank_t b);
    logic [PTW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PTW] ? RANK_MAX : sum[PTW-1:0];
  endfunction

  function automatic rank_t max_rank(input rank_t a, input rank_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aether_stfq_ranker_if.sv
// Bundle of descriptor, PIFO push, PIFO dequeue and (optional) weight config
// signals for the STFQ ranker. Config signals exist only with STFQ_WEIGHT_EN.
// The slave modport is the ranker; the master modport is its environment.
interface aether_stfq_ranker_if;
  import aether_pifo_pkg::*;

  // Descriptor input
  logic       i_pkt_valid;
  logic       o_pkt_ready;
  flow_t      i_pkt_flow;
  len_t       i_pkt_len;
  meta_t      i_pkt_meta;

  // PIFO push port
  logic       o_push;
  push_word_t o_push_data;
  logic       i_pifo_ready;

  // PIFO dequeue feedback for virtual time
  logic       i_deq_valid;
  rank_t      i_deq_rank;

`ifdef STFQ_WEIGHT_EN
  // Per-flow weight configuration
  logic       i_cfg_we;
  flow_t      i_cfg_flow;
  shift_t     i_cfg_shift;
`endif

  modport slave (
    input  i_pkt_valid, i_pkt_flow, i_pkt_len, i_pkt_meta,
    input  i_pifo_ready, i_deq_valid, i_deq_rank,
`ifdef STFQ_WEIGHT_EN
    input  i_cfg_we, i_cfg_flow, i_cfg_shift,
`endif
    output o_pkt_ready, o_push, o_push_data
  );

  modport master (
    output i_pkt_valid, i_pkt_flow, i_pkt_len, i_pkt_meta,
    output i_pifo_ready, i_deq_valid, i_deq_rank,
`ifdef STFQ_WEIGHT_EN
    output i_cfg_we, i_cfg_flow, i_cfg_shift,
`endif
    input  o_pkt_ready, o_push, o_push_data
  );

endinterface

// File: rtl/aether_stfq_ranker_flow_table.sv
// Per-flow state for the STFQ ranker: last finish tag per flow (and, with
// STFQ_WEIGHT_EN, a per-flow length shift). One asynchronous read port and
// one write port each; everything clears on reset.
module aether_stfq_flow_table
  import aether_pifo_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_arst,
  input  flow_t  rd_flow,
  output rank_t  rd_finish,
  input  logic   wr_en,
  input  flow_t  wr_flow,
  input  rank_t  wr_finish
`ifdef STFQ_WEIGHT_EN
  ,
  output shift_t rd_shift,
  input  logic   cfg_we,
  input  flow_t  cfg_flow,
  input  shift_t cfg_shift
`endif
);

  rank_t finish_q [NUM_FLOWS];

  // Finish tag storage: written when a packet leaves S1.
  // NOTE: the table is a handful of flops, so it takes the async reset like
  // any other state; a RAM-style array without reset would start with garbage tags.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < NUM_FLOWS; i++) finish_q[i] <= '0;
    end else if (wr_en) begin
      finish_q[wr_flow] <= wr_finish;
    end
  end

  assign rd_finish = finish_q[rd_flow];

`ifdef STFQ_WEIGHT_EN
  shift_t shift_q [NUM_FLOWS];

  // Weight storage: a config write lands at the edge, so a same-cycle reader sees the old value.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < NUM_FLOWS; i++) shift_q[i] <= '0;
    end else if (cfg_we) begin
      shift_q[cfg_flow] <= cfg_shift;
    end
  end

  assign rd_shift = shift_q[rd_flow];
`endif

endmodule

// File: rtl/aether_stfq_ranker.sv
// Start-Time Fair Queueing rank generator feeding the Aether PIFO push port.
// S1 holds an accepted descriptor and computes start/finish tags against the
// flow table and virtual time; S2 is the registered push word to the PIFO.
// Virtual time follows the largest rank the PIFO has dequeued.
// Optional feature: define STFQ_WEIGHT_EN for per-flow length shifts.
module aether_stfq_ranker
  import aether_pifo_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_arst,
  aether_stfq_ranker_if.slave  bus
);

  // S1 descriptor stage
  logic       s1_valid;
  flow_t      s1_flow;
  len_t       s1_len;
  meta_t      s1_meta;

  // S2 push stage
  logic       push_q;
  push_word_t push_data_q;

  // Global virtual time
  rank_t      v_q;

  // S1 combinational results
  rank_t      f_rd;
  rank_t      start_rank;
  rank_t      scaled_len;
  rank_t      finish_rank;
  logic       s2_free;
  logic       s1_xfer;
  logic       pkt_ready;
  logic       pkt_accept;

`ifdef STFQ_WEIGHT_EN
  shift_t     s1_shift;
`endif

  aether_stfq_flow_table u_table (
    .i_clk     (i_clk),
    .i_arst    (i_arst),
    .rd_flow   (s1_flow),
    .rd_finish (f_rd),
`ifdef STFQ_WEIGHT_EN
    .rd_shift  (s1_shift),
    .cfg_we    (bus.i_cfg_we),
    .cfg_flow  (bus.i_cfg_flow),
    .cfg_shift (bus.i_cfg_shift),
`endif
    .wr_en     (s1_xfer),
    .wr_flow   (s1_flow),
    .wr_finish (finish_rank)
  );

  // Tag arithmetic and handshake decisions for the descriptor sitting in S1.
  // NOTE: every signal gets a value on every path through this block, so no latch can form.
  always_comb begin
    s2_free     = !push_q || bus.i_pifo_ready;
    s1_xfer     = s1_valid && s2_free;
    pkt_ready   = !s1_valid || s1_xfer;
    pkt_accept  = bus.i_pkt_valid && pkt_ready;
    start_rank  = max_rank(v_q, f_rd);
`ifdef STFQ_WEIGHT_EN
    scaled_len  = rank_t'(s1_len >> s1_shift);
`else
    scaled_len  = rank_t'(s1_len);
`endif
    finish_rank = sat_add(start_rank, scaled_len);
  end

  // S1 load/drain: a new descriptor may enter in the same edge the old one leaves.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      s1_valid <= 1'b0;
      s1_flow  <= '0;
      s1_len   <= '0;
      s1_meta  <= '0;
    end else if (pkt_accept) begin
      s1_valid <= 1'b1;
      s1_flow  <= bus.i_pkt_flow;
      s1_len   <= bus.i_pkt_len;
      s1_meta  <= bus.i_pkt_meta;
    end else if (s1_xfer) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 push register: holds its word stable while the PIFO is not ready.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else if (s1_xfer) begin
      push_q           <= 1'b1;
      push_data_q.meta <= s1_meta;
      push_data_q.rank <= start_rank;
    end else if (push_q && bus.i_pifo_ready) begin
      push_q <= 1'b0;
    end
  end

  // Virtual time only moves forward, tracking the largest dequeued rank.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      v_q <= '0;
    end else if (bus.i_deq_valid) begin
      v_q <= max_rank(v_q, bus.i_deq_rank);
    end
  end

  assign bus.o_pkt_ready = pkt_ready;
  assign bus.o_push      = push_q;
  assign bus.o_push_data = push_data_q;

endmodule

// File: tb/tb_aether_stfq_ranker.sv
// Self-checking bench for aether_stfq_ranker: directed scenarios followed by
// randomized traffic, checked by a scoreboard against an integer STFQ model.
// Weight scenarios are compiled in when STFQ_WEIGHT_EN is defined.
module tb_aether_stfq_ranker;
  import aether_pifo_pkg::*;

  logic clk = 1'b0;
  logic arst;

  always #5 clk = ~clk;

  aether_stfq_ranker_if u_if ();

  aether_stfq_ranker u_dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (u_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  push_word_t exp_q [$];

  // Reference model state: plain integers, STFQ rules applied directly.
  int unsigned m_fin [NUM_FLOWS];
  int unsigned m_w   [NUM_FLOWS];
  int unsigned m_v;

  bit mon_en  = 1'b0;
  bit rand_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FLOWS; i++) begin
      m_fin[i] = 0;
      m_w[i]   = 0;
    end
    m_v = 0;
  endtask

  // Offer one descriptor; the expectation is queued when the bench sees it accepted.
  // A non-negative exp_rank pins the expected rank to a hand-derived constant.
  task automatic send(input int flow, input int len, input int exp_rank = -1);
    meta_t       meta;
    int unsigned start, fin;
    rank_t       r;
    bit          done;
    meta = $urandom;
    done = 1'b0;
    u_if.i_pkt_valid = 1'b1;
    u_if.i_pkt_flow  = flow_t'(flow);
    u_if.i_pkt_len   = len_t'(len);
    u_if.i_pkt_meta  = meta;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (u_if.o_pkt_ready) begin
        start = (m_v > m_fin[flow]) ? m_v : m_fin[flow];
        fin   = start + (int'(len) >> m_w[flow]);
        if (fin > 65535) fin = 65535;
        m_fin[flow] = fin;
        r = (exp_rank >= 0) ? rank_t'(exp_rank) : rank_t'(start);
        exp_q.push_back('{meta: meta, rank: r});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    u_if.i_pkt_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: flow %0d never accepted", flow);
    end
  endtask

  // Wait until every accepted descriptor has been pushed and consumed.
  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 1000 && !idle; c++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !u_if.o_push;
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d", exp_q.size());
    end
  endtask

  task automatic deq(input int unsigned rank);
    wait_idle();
    u_if.i_deq_valid = 1'b1;
    u_if.i_deq_rank  = rank_t'(rank);
    @(posedge clk);
    #1;
    u_if.i_deq_valid = 1'b0;
    if (rank > m_v) m_v = rank;
  endtask

`ifdef STFQ_WEIGHT_EN
  task automatic cfg(input int flow, input int shift);
    wait_idle();
    u_if.i_cfg_we    = 1'b1;
    u_if.i_cfg_flow  = flow_t'(flow);
    u_if.i_cfg_shift = shift_t'(shift);
    @(posedge clk);
    #1;
    u_if.i_cfg_we = 1'b0;
    m_w[flow] = shift;
  endtask
`endif

  // Monitor: compares each consumed push word and checks stability under stall.
  initial begin
    push_word_t held;
    push_word_t e;
    bit         stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || arst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("hold_push", 64'(u_if.o_push), 64'd1);
        check("hold_data", 64'(u_if.o_push_data), 64'(held));
      end
      if (u_if.o_push && u_if.i_pifo_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_push: actual=0x%0h required=none", u_if.o_push_data);
        end else begin
          e = exp_q.pop_front();
          check("push_data", 64'(u_if.o_push_data), 64'(e));
        end
      end
      stalled = u_if.o_push && !u_if.i_pifo_ready;
      held    = u_if.o_push_data;
    end
  end

  // Random PIFO backpressure, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) u_if.i_pifo_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    arst             = 1'b1;
    u_if.i_pkt_valid = 1'b0;
    u_if.i_pkt_flow  = '0;
    u_if.i_pkt_len   = '0;
    u_if.i_pkt_meta  = '0;
    u_if.i_pifo_ready = 1'b1;
    u_if.i_deq_valid = 1'b0;
    u_if.i_deq_rank  = '0;
`ifdef STFQ_WEIGHT_EN
    u_if.i_cfg_we    = 1'b0;
    u_if.i_cfg_flow  = '0;
    u_if.i_cfg_shift = '0;
`endif
    model_reset();

    // Reset state
    #1;
    check("rst_push", 64'(u_if.o_push), 64'd0);
    check("rst_data", 64'(u_if.o_push_data), 64'd0);
    check("rst_ready", 64'(u_if.o_pkt_ready), 64'd1);
    @(negedge clk);
    arst   = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic start tags
    send(0, 100, 0);
    send(1, 50, 0);
    send(0, 30, 100);

    // Virtual time advance and no-decrease
    deq(80);
    send(1, 10, 80);
    deq(40);
    send(1, 5, 90);

    // Backpressure: 3 descriptors against a stalled PIFO for 5 cycles
    wait_idle();
    @(posedge clk);
    #1;
    u_if.i_pifo_ready = 1'b0;
    fork
      begin
        send(4, 10);
        send(5, 20);
        send(4, 7);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp_ready_low", 64'(u_if.o_pkt_ready), 64'd0);
        check("bp_push_held", 64'(u_if.o_push), 64'd1);
        u_if.i_pifo_ready = 1'b1;
      end
    join

    // Saturation near the top of the rank space
    deq(65500);
    send(2, 100, 65500);
    send(2, 1, 65535);

    // Asynchronous reset with S1 and S2 occupied
    wait_idle();
    @(posedge clk);
    #1;
    u_if.i_pifo_ready = 1'b0;
    send(6, 20);
    send(7, 30);
    check("pre_rst_push", 64'(u_if.o_push), 64'd1);
    check("pre_rst_ready", 64'(u_if.o_pkt_ready), 64'd0);
    mon_en = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    check("mid_rst_push", 64'(u_if.o_push), 64'd0);
    check("mid_rst_ready", 64'(u_if.o_pkt_ready), 64'd1);
    check("mid_rst_data", 64'(u_if.o_push_data), 64'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    arst              = 1'b0;
    u_if.i_pifo_ready = 1'b1;
    mon_en            = 1'b1;
    @(posedge clk);
    #1;
    send(0, 5, 0);

`ifdef STFQ_WEIGHT_EN
    // Weighted flow: shift 2 quarters the length charge
    cfg(3, 2);
    send(3, 400, 0);
    send(3, 400, 100);
`endif

    // Randomized traffic with random backpressure and dequeue feedback
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = m_v + $urandom_range(0, 300);
        r = (r >= 100) ? r - 100 : 0;
        if (r > 65535) r = 65535;
        deq(r);
      end
`ifdef STFQ_WEIGHT_EN
      if ($urandom_range(0, 24) == 0) cfg($urandom_range(0, NUM_FLOWS - 1), $urandom_range(0, 15));
`endif
      send($urandom_range(0, NUM_FLOWS - 1), $urandom_range(0, 600));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    u_if.i_pifo_ready = 1'b1;
    wait_idle();
    check("final_pending", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
